// File: rtl/irq_dispatch_if.sv
// rtl/irq_dispatch_if.sv - upstream/CPU-side signal bundle for the interrupt dispatcher
interface irq_dispatch_if;
    logic [1:0] irq_active;
    logic       cpu_irq_take;
    logic       cpu_irq_done;
    logic       err_clr;
    logic       cpu_irq;
    logic       cpu_irq_id;
    logic [1:0] ack;
    logic       busy;
    logic       timeout_err;

    modport master (
        output irq_active, cpu_irq_take, cpu_irq_done, err_clr,
        input  cpu_irq, cpu_irq_id, ack, busy, timeout_err
    );

    modport slave (
        input  irq_active, cpu_irq_take, cpu_irq_done, err_clr,
        output cpu_irq, cpu_irq_id, ack, busy, timeout_err
    );
endinterface

// File: rtl/irq_dispatch.sv
// rtl/irq_dispatch.sv - fixed-priority two-line interrupt dispatcher with take timeout and post-ack guard
module irq_dispatch #(
    parameter int TIMEOUT_CYC = 64,
    parameter int GUARD_CYC   = 2,
    parameter int CNT_W       = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    irq_dispatch_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_SERVICE = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_GUARD   = 3'd4;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GD_LAST = CNT_W'(GUARD_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             id_q, id_d;
    logic             err_q, err_d;
    logic             cpu_irq_q;
    logic             cpu_irq_id_q;
    logic [1:0]       ack_q;
    logic             busy_q;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        err_d   = err_q & ~bus.err_clr;
        case (state_q)
            S_IDLE: begin
                if (|bus.irq_active) begin
                    id_d    = ~bus.irq_active[0];
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                // Withdrawal outranks take, which outranks timeout.
                if (!bus.irq_active[id_q]) begin
                    state_d = S_IDLE;
                end else if (bus.cpu_irq_take) begin
                    state_d = S_SERVICE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_SERVICE: begin
                if (bus.cpu_irq_done) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                cnt_d   = '0;
                state_d = S_GUARD;
            end
            S_GUARD: begin
                cnt_d = cnt_inc;
                if (cnt_q == GD_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from next-state so they are registered yet aligned with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            cpu_irq_q    <= 1'b0;
            cpu_irq_id_q <= 1'b0;
            ack_q        <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            err_q        <= err_d;
            cpu_irq_q    <= (state_d == S_REQ);
            cpu_irq_id_q <= id_d;
            ack_q        <= (state_d == S_ACK) ? (id_d ? 2'b10 : 2'b01) : 2'b00;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign bus.cpu_irq     = cpu_irq_q;
    assign bus.cpu_irq_id  = cpu_irq_id_q;
    assign bus.ack         = ack_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_irq_dispatch.sv
// tb/tb_irq_dispatch.sv - randomized transaction bench with event scoreboard for irq_dispatch
module tb_irq_dispatch;
    localparam int T = 4;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    irq_dispatch_if bus();

    irq_dispatch #(.TIMEOUT_CYC(T), .GUARD_CYC(G), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] val;
        logic       err;
    } ev_t;

    ev_t rise_q[$];
    ev_t fall_q[$];
    ev_t ack_q[$];
    ev_t busy_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic err_model = 1'b0;
    logic clr_en = 1'b1;
    logic mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen at cycle %0d with nothing expected", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs set here are seen by the DUT at the next rising edge; is_to marks the timeout edge.
    task automatic drive(input logic take, input logic done, input logic [1:0] act,
                         input logic clr, input logic is_to);
        bus.cpu_irq_take = take;
        bus.cpu_irq_done = done;
        bus.irq_active   = act;
        bus.err_clr      = clr;
        if (is_to)    err_model = 1'b1;
        else if (clr) err_model = 1'b0;
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic rclr();
        return clr_en && ($urandom_range(0, 7) == 0);
    endfunction

    function automatic logic [1:0] keep(input logic id);
        return 2'($urandom_range(0, 3)) | (id ? 2'b10 : 2'b01);
    endfunction

    task automatic run_txn(input int force_mode);
        logic [1:0] pat;
        logic       id;
        int         ks, mode, td, dd, w, a, gap;
        pat  = 2'($urandom_range(1, 3));
        id   = ~pat[0];
        mode = (force_mode >= 0) ? force_mode : $urandom_range(0, 5);
        tick();
        drive(1'b0, 1'b0, pat, rclr(), 1'b0);
        ks = cyc + 1;
        rise_q.push_back('{ks, {1'b0, id}, 1'b0});
        if (mode == 5) begin
            w = $urandom_range(1, T);
            for (int j = 1; j <= w; j++) begin
                tick();
                drive((j == w) ? rbit() : 1'b0, rbit(), (j == w) ? 2'b00 : keep(id), rclr(), 1'b0);
            end
            fall_q.push_back('{ks + w, 2'b00, 1'b0});
            busy_q.push_back('{ks + w, 2'b00, 1'b0});
        end else begin
            if (mode == 4) begin
                for (int j = 1; j <= T; j++) begin
                    tick();
                    drive(1'b0, rbit(), keep(id), rclr(), j == T);
                end
                a = ks + T;
                fall_q.push_back('{a, 2'b00, 1'b0});
            end else begin
                td = $urandom_range(1, T);
                for (int j = 1; j <= td; j++) begin
                    tick();
                    drive(j == td, rbit(), keep(id), rclr(), 1'b0);
                end
                fall_q.push_back('{ks + td, 2'b00, 1'b0});
                dd = $urandom_range(1, 6);
                for (int d = 1; d <= dd; d++) begin
                    tick();
                    drive(rbit(), d == dd, 2'($urandom_range(0, 3)), rclr(), 1'b0);
                end
                a = ks + td + dd;
            end
            ack_q.push_back('{a, id ? 2'b10 : 2'b01, err_model});
            busy_q.push_back('{a + G + 1, 2'b00, 1'b0});
            for (int i = 1; i <= G + 1; i++) begin
                tick();
                drive(rbit(), rbit(), 2'($urandom_range(0, 3)), rclr(), 1'b0);
            end
        end
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            tick();
            drive(1'b0, 1'b0, 2'b00, rclr(), 1'b0);
        end
    endtask

    initial begin
        ev_t  e;
        logic p_irq  = 1'b0;
        logic p_busy = 1'b0;
        logic [1:0] p_ack = 2'b00;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.cpu_irq && !p_irq) begin
                    if (rise_q.size() == 0) flag_fail("irq_rise_unexpected");
                    else begin
                        e = rise_q.pop_front();
                        check("irq_rise_cycle", cyc, e.cyc);
                        check("irq_id", int'(bus.cpu_irq_id), int'(e.val));
                    end
                end
                if (!bus.cpu_irq && p_irq) begin
                    if (fall_q.size() == 0) flag_fail("irq_fall_unexpected");
                    else begin
                        e = fall_q.pop_front();
                        check("irq_fall_cycle", cyc, e.cyc);
                    end
                end
                if (bus.ack != 2'b00) begin
                    if (p_ack != 2'b00) flag_fail("ack_width");
                    else if (ack_q.size() == 0) flag_fail("ack_unexpected");
                    else begin
                        e = ack_q.pop_front();
                        check("ack_cycle", cyc, e.cyc);
                        check("ack_value", int'(bus.ack), int'(e.val));
                        check("ack_timeout_err", int'(bus.timeout_err), int'(e.err));
                    end
                end
                if (!bus.busy && p_busy) begin
                    if (busy_q.size() == 0) flag_fail("busy_fall_unexpected");
                    else begin
                        e = busy_q.pop_front();
                        check("busy_fall_cycle", cyc, e.cyc);
                    end
                end
            end
            p_irq  = bus.cpu_irq;
            p_ack  = bus.ack;
            p_busy = bus.busy;
        end
    end

    initial begin
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_irq", int'(bus.cpu_irq), 0);
        check("rst_cpu_irq_id", int'(bus.cpu_irq_id), 0);
        check("rst_ack", int'(bus.ack), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_timeout_err", int'(bus.timeout_err), 0);
        rst_n = 1'b1;

        tick();
        drive(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        tick();
        check("req_cpu_irq", int'(bus.cpu_irq), 1);
        tick();
        drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        tick();
        check("svc_busy", int'(bus.busy), 1);
        check("svc_cpu_irq", int'(bus.cpu_irq), 0);
        #2 rst_n = 1'b0;
        #1;
        check("midsvc_rst_busy", int'(bus.busy), 0);
        check("midsvc_rst_ack", int'(bus.ack), 0);
        check("midsvc_rst_cpu_irq", int'(bus.cpu_irq), 0);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("post_rst_ack", int'(bus.ack), 0);
        check("post_rst_busy", int'(bus.busy), 0);

        mon_en = 1'b1;
        for (int n = 0; n < 200; n++) run_txn(-1);

        clr_en = 1'b0;
        run_txn(4);
        tick();
        check("err_sticky", int'(bus.timeout_err), 1);
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick();
        check("err_cleared", int'(bus.timeout_err), 0);

        repeat (10) tick();
        check("rise_left", rise_q.size(), 0);
        check("fall_left", fall_q.size(), 0);
        check("ack_left", ack_q.size(), 0);
        check("busy_left", busy_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
